// File: rtl/ga_pkg.sv
// Shared constants and types for the Gate Array sync/interrupt stage.
// No logic here; no latency or backpressure of its own.
package ga_pkg;

    localparam int INT_LINES_DEF = 52;
    localparam int VS_LINES_DEF  = 26;
    localparam int INT_VS_THRESH = 32;

    // Monitor HSYNC window, in CLKEN samples since the CRTC HSYNC rise.
    localparam int HS_DELAY = 2;
    localparam int HS_END   = 6;

    typedef logic [1:0] mode_t;

endpackage

// File: rtl/ga_int_counter.sv
// Raster interrupt line counter, VSYNC re-sync hold, ACK/RESET arbitration and nINT.
// Latency: updates on the CLKEN cycle that sees the HSYNC fall; ACK/RESET act on any CLOCK; no backpressure.
module ga_int_counter
    import ga_pkg::*;
#(
    parameter int INT_LINES = INT_LINES_DEF
)
(
    input  logic       CLOCK,
    input  logic       nRESET,
    input  logic       hs_fall,
    input  logic       vs_rise,
    input  logic       INT_ACK,
    input  logic       INT_RESET,
    output logic [5:0] int_cnt,
    output logic       n_int
);

    localparam logic [6:0] WRAP   = 7'(INT_LINES);
    localparam logic [6:0] THRESH = 7'(INT_VS_THRESH);

    logic [1:0] vs_hold;
    logic [1:0] vs_hold_nxt;
    logic [5:0] cnt_nxt;
    logic       nint_nxt;
    logic [6:0] line_n;
    logic       raise;

    always_comb begin
        vs_hold_nxt = vs_hold;
        cnt_nxt     = int_cnt;
        nint_nxt    = n_int;
        raise       = 1'b0;
        line_n      = {1'b0, int_cnt} + 7'd1;

        if (hs_fall) begin
            if (line_n == WRAP) begin
                cnt_nxt = '0;
                raise   = 1'b1;
            end else begin
                cnt_nxt = line_n[5:0];
            end
            // Second HSYNC after VSYNC: re-sync the counter to the frame.
            if (vs_hold != 2'd0) begin
                vs_hold_nxt = vs_hold - 2'd1;
                if (vs_hold == 2'd1) begin
                    cnt_nxt = '0;
                    if (line_n >= THRESH) begin
                        raise = 1'b1;
                    end
                end
            end
        end

        if (vs_rise) begin
            vs_hold_nxt = 2'd2;
        end

        if (INT_ACK) begin
            nint_nxt   = 1'b1;
            cnt_nxt[5] = 1'b0;
        end

        if (raise) begin
            nint_nxt = 1'b0;
        end

        if (INT_RESET) begin
            cnt_nxt  = '0;
            nint_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            vs_hold <= 2'd0;
            int_cnt <= '0;
            n_int   <= 1'b1;
        end else begin
            vs_hold <= vs_hold_nxt;
            int_cnt <= cnt_nxt;
            n_int   <= nint_nxt;
        end
    end

endmodule

// File: rtl/ga_sync_int.sv
// Gate Array sync stage: monitor HSYNC/VSYNC reshaping, raster interrupt, line-boundary mode latch.
// Latency one CLKEN character (HSYNC delayed 2 more with GA_HSYNC_DELAY_EN); no backpressure.
module ga_sync_int
    import ga_pkg::*;
#(
    parameter int INT_LINES = INT_LINES_DEF,
    parameter int VS_LINES  = VS_LINES_DEF
)
(
    input  logic       CLOCK,
    input  logic       nRESET,
    input  logic       CLKEN,
    input  logic       HSYNC_IN,
    input  logic       VSYNC_IN,
    input  logic       INT_ACK,
    input  logic       INT_RESET,
    input  logic       MODE_WR,
    input  logic [1:0] MODE_DI,
    output logic       HSYNC_OUT,
    output logic       VSYNC_OUT,
    output logic       nINT,
    output logic [1:0] MODE,
    output logic [5:0] INT_CNT
);

    localparam int VSW = $clog2(VS_LINES + 1);
    localparam logic [VSW-1:0] VS_END = VSW'(VS_LINES);

    logic           hs_prev;
    logic           vs_prev;
    logic           hs_rise;
    logic           hs_fall;
    logic           vs_rise;
    logic           vs_fall;
    logic           vs_out;
    logic [VSW-1:0] vs_cnt;
    logic [VSW-1:0] vs_cnt_inc;
    logic           hs_out;
    mode_t          mode_q;
    mode_t          mode_pend;

    assign hs_rise    = CLKEN &  HSYNC_IN & ~hs_prev;
    assign hs_fall    = CLKEN & ~HSYNC_IN &  hs_prev;
    assign vs_rise    = CLKEN &  VSYNC_IN & ~vs_prev;
    assign vs_fall    = CLKEN & ~VSYNC_IN &  vs_prev;
    assign vs_cnt_inc = vs_cnt + VSW'(1);

    ga_int_counter #(
        .INT_LINES (INT_LINES)
    ) u_int_counter (
        .CLOCK     (CLOCK),
        .nRESET    (nRESET),
        .hs_fall   (hs_fall),
        .vs_rise   (vs_rise),
        .INT_ACK   (INT_ACK),
        .INT_RESET (INT_RESET),
        .int_cnt   (INT_CNT),
        .n_int     (nINT)
    );

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            hs_prev   <= 1'b0;
            vs_prev   <= 1'b0;
            mode_q    <= '0;
            mode_pend <= '0;
            vs_out    <= 1'b0;
            vs_cnt    <= '0;
        end else begin
            if (CLKEN) begin
                hs_prev <= HSYNC_IN;
                vs_prev <= VSYNC_IN;
            end

            if (MODE_WR) begin
                mode_pend <= MODE_DI;
            end
            // A write landing on the rise itself is taken by that rise.
            if (hs_rise) begin
                mode_q <= MODE_WR ? MODE_DI : mode_pend;
            end

            if (vs_rise) begin
                vs_out <= 1'b1;
                vs_cnt <= '0;
            end else if (vs_out) begin
                if (vs_fall) begin
                    vs_out <= 1'b0;
                end else if (hs_fall) begin
                    vs_cnt <= vs_cnt_inc;
                    if (vs_cnt_inc == VS_END) begin
                        vs_out <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef GA_HSYNC_DELAY_EN
    logic [2:0] hs_cnt;
    logic [2:0] hs_cnt_nxt;

    always_comb begin
        hs_cnt_nxt = hs_cnt;
        if (HSYNC_IN) begin
            if (!hs_prev) begin
                hs_cnt_nxt = 3'd0;
            end else if (hs_cnt != 3'(HS_END)) begin
                hs_cnt_nxt = hs_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            hs_cnt <= 3'd0;
            hs_out <= 1'b0;
        end else if (CLKEN) begin
            hs_cnt <= hs_cnt_nxt;
            hs_out <= HSYNC_IN && (hs_cnt_nxt >= 3'(HS_DELAY)) && (hs_cnt_nxt < 3'(HS_END));
        end
    end
`else
    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            hs_out <= 1'b0;
        end else if (CLKEN) begin
            hs_out <= HSYNC_IN;
        end
    end
`endif

    assign HSYNC_OUT = hs_out;
    assign VSYNC_OUT = vs_out;
    assign MODE      = mode_q;

endmodule

// File: tb/tb_ga_sync_int.sv
// Randomized CRTC-like raster stimulus against a behavioural model; scoreboard queue checked every CLOCK.
module tb_ga_sync_int;

    localparam int NCYC   = 30000;
    localparam int RST_AT = 15000;

    logic       CLOCK = 1'b0;
    logic       nRESET;
    logic       CLKEN;
    logic       HSYNC_IN;
    logic       VSYNC_IN;
    logic       INT_ACK;
    logic       INT_RESET;
    logic       MODE_WR;
    logic [1:0] MODE_DI;
    logic       HSYNC_OUT;
    logic       VSYNC_OUT;
    logic       nINT;
    logic [1:0] MODE;
    logic [5:0] INT_CNT;

    always #5 CLOCK = ~CLOCK;

    ga_sync_int dut (
        .CLOCK     (CLOCK),
        .nRESET    (nRESET),
        .CLKEN     (CLKEN),
        .HSYNC_IN  (HSYNC_IN),
        .VSYNC_IN  (VSYNC_IN),
        .INT_ACK   (INT_ACK),
        .INT_RESET (INT_RESET),
        .MODE_WR   (MODE_WR),
        .MODE_DI   (MODE_DI),
        .HSYNC_OUT (HSYNC_OUT),
        .VSYNC_OUT (VSYNC_OUT),
        .nINT      (nINT),
        .MODE      (MODE),
        .INT_CNT   (INT_CNT)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       nint;
        logic [1:0] mode;
        logic [5:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state (frame-level view of the Gate Array).
    int m_cnt, m_hold, m_vslines, m_mode, m_pend;
    bit m_nint, m_hsout, m_vsout, m_hsprev, m_vsprev;
`ifdef GA_HSYNC_DELAY_EN
    int m_hsrun;
`endif

    task automatic model_step(input bit rst, input bit ck, input bit hs, input bit vs,
                              input bit ack, input bit ir, input bit wr, input int di);
        bit   hf, hr, vf, vr, irq;
        int   nc, line;
        exp_t e;
        if (!rst) begin
            m_cnt = 0; m_hold = 0; m_vslines = 0; m_mode = 0; m_pend = 0;
            m_nint = 1; m_hsout = 0; m_vsout = 0; m_hsprev = 0; m_vsprev = 0;
        end else begin
            hf  = ck && !hs && m_hsprev;
            hr  = ck &&  hs && !m_hsprev;
            vf  = ck && !vs && m_vsprev;
            vr  = ck &&  vs && !m_vsprev;
            irq = 0;
            nc  = m_cnt;
            if (hf) begin
                line = m_cnt + 1;
                if (line == 52) begin
                    nc = 0; irq = 1;
                end else begin
                    nc = line;
                end
                if (m_hold > 0) begin
                    m_hold = m_hold - 1;
                    if (m_hold == 0) begin
                        nc = 0;
                        if (line >= 32) irq = 1;
                    end
                end
            end
            if (vr) m_hold = 2;
            if (ack) begin
                m_nint = 1;
                nc = nc % 32;
            end
            if (irq) m_nint = 0;
            if (ir) begin
                nc = 0; m_nint = 1;
            end
            m_cnt = nc;

            if (hr) m_mode = wr ? di : m_pend;
            if (wr) m_pend = di;

            if (vr) begin
                m_vsout = 1; m_vslines = 0;
            end else if (m_vsout) begin
                if (vf) m_vsout = 0;
                else if (hf) begin
                    m_vslines = m_vslines + 1;
                    if (m_vslines == 26) m_vsout = 0;
                end
            end

            if (ck) begin
`ifdef GA_HSYNC_DELAY_EN
                if (hs) m_hsrun = hr ? 0 : m_hsrun + 1;
                m_hsout = hs && (m_hsrun >= 2) && (m_hsrun <= 5);
`else
                m_hsout = hs;
`endif
                m_hsprev = hs;
                m_vsprev = vs;
            end
        end
        e.hs   = m_hsout;
        e.vs   = m_vsout;
        e.nint = m_nint;
        e.mode = 2'(m_mode);
        e.cnt  = 6'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, got, want);
        end
    endtask

    // Monitor: the DUT presents a fresh output set after every CLOCK edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("int_cnt",   {2'b00, INT_CNT}, {2'b00, e.cnt});
                chk("nint",      {7'd0, nINT},     {7'd0, e.nint});
                chk("mode",      {6'd0, MODE},     {6'd0, e.mode});
                chk("hsync_out", {7'd0, HSYNC_OUT}, {7'd0, e.hs});
                chk("vsync_out", {7'd0, VSYNC_OUT}, {7'd0, e.vs});
            end
        end
    end

    // CRTC-like raster generator state.
    int g_ch, g_ht, g_hpos, g_hw, g_vs_left, g_gap;

    task automatic new_line();
        int sel;
        sel = $urandom_range(0, 5);
        g_hw = (sel == 0) ? 14 : (sel == 1) ? 2 : (sel == 2) ? 1 : $urandom_range(1, 14);
        g_hpos = $urandom_range(2, 5);
        g_ht = g_hpos + g_hw + $urandom_range(2, 6);
        if (g_vs_left > 0) begin
            g_vs_left--;
        end else if (g_gap == 0) begin
            sel = $urandom_range(0, 4);
            g_vs_left = (sel == 0) ? 32 : (sel == 1) ? 8 : (sel == 2) ? 40 :
                        (sel == 3) ? 2 : $urandom_range(1, 30);
            g_gap = $urandom_range(20, 120);
        end else begin
            g_gap--;
        end
    endtask

    initial begin
        bit rst, ck, hs, vs, ack, ir, wr, fall_p, rise_p;
        int di;
        nRESET = 0; CLKEN = 0; HSYNC_IN = 0; VSYNC_IN = 0;
        INT_ACK = 0; INT_RESET = 0; MODE_WR = 0; MODE_DI = 0;
        g_ch = 0; g_vs_left = 0; g_gap = 5;
        new_line();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge CLOCK);
            rst = !(cyc < 3 || (cyc >= RST_AT && cyc < RST_AT + 2));
            ck  = ($urandom_range(0, 2) != 0);
            hs  = (g_ch >= g_hpos) && (g_ch < g_hpos + g_hw);
            vs  = (g_vs_left > 0);
            fall_p = rst && ck && !hs && m_hsprev;
            rise_p = rst && ck &&  hs && !m_hsprev;

            // Bias strobes onto the interesting coincidences with the line boundary.
            if (fall_p && m_cnt == 51 && $urandom_range(0, 1) == 1) ack = 1;
            else if (!m_nint && $urandom_range(0, 39) == 0)         ack = 1;
            else                                                     ack = ($urandom_range(0, 499) == 0);
            if (fall_p && m_cnt == 51 && ack && $urandom_range(0, 3) == 0) ir = 1;
            else                                                           ir = ($urandom_range(0, 2999) == 0);
            if (rise_p && $urandom_range(0, 3) == 0) wr = 1;
            else                                     wr = ($urandom_range(0, 59) == 0);
            di = $urandom_range(0, 3);

            nRESET = rst; CLKEN = ck; HSYNC_IN = hs; VSYNC_IN = vs;
            INT_ACK = ack; INT_RESET = ir; MODE_WR = wr; MODE_DI = 2'(di);
            model_step(rst, ck, hs, vs, ack, ir, wr, di);

            if (ck) begin
                g_ch++;
                if (g_ch == g_ht) begin
                    g_ch = 0;
                    new_line();
                end
            end
        end
        @(negedge CLOCK);
        INT_ACK = 0; INT_RESET = 0; MODE_WR = 0; CLKEN = 0;
        repeat (2) @(negedge CLOCK);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
